instruction_decoder: RTL and testbench

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

---
 rtl/instruction_decoder.sv | 164 ++++++++++++++++
 tb/tb_instruction_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// Decodes instruction words into buffer/array strobe bursts with
// linearly incrementing buffer addresses; HALT parks the decoder until reset.
//
// state    | meaning
// IDLE     | ready for a word; no strobe
// EXEC     | driving one strobe per cycle for the latched burst
// HALTED   | HALT retired; everything ignored until reset
module instruction_decoder #(
    parameter int INSTRUCTION_SIZE = 32,
    parameter int ADDR_WIDTH       = 8,
    parameter int LEN_WIDTH        = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        instr_valid,
    input  logic [INSTRUCTION_SIZE-1:0] instruction,
    output logic                        instr_ready,
    output logic                        weight_we,
    output logic                        input_re,
    output logic                        sa_en,
    output logic                        output_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic                        busy,
    output logic                        halted,
    output logic                        illegal
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam int OP_LSB   = INSTRUCTION_SIZE - 4;
    localparam int BASE_LSB = OP_LSB - ADDR_WIDTH;
    localparam int LEN_LSB  = BASE_LSB - LEN_WIDTH;

    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] base_in;
    logic [LEN_WIDTH-1:0]  len_in;
    logic                  burst_op;

    assign opcode   = instruction[INSTRUCTION_SIZE-1 -: 4];
    assign base_in  = instruction[OP_LSB-1 -: ADDR_WIDTH];
    assign len_in   = instruction[BASE_LSB-1 -: LEN_WIDTH];
    assign burst_op = (opcode != OP_NOP) && (opcode <= 4'd4);

    generate
        if (LEN_LSB > 0) begin : g_spare_bits
            logic unused_spare;
            assign unused_spare = ^instruction[LEN_LSB-1:0];
        end
    endgenerate

    // strobe vector bit order: {output_we, sa_en, input_re, weight_we}
    function automatic logic [3:0] strobe_of(input logic [3:0] op);
        case (op)
            4'd1:    return 4'b0001;
            4'd2:    return 4'b0010;
            4'd3:    return 4'b0100;
            4'd4:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    logic [1:0]            state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] off_q, off_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [3:0]            strb_q, strb_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  busy_q, busy_d;
    logic                  halted_q, halted_d;
    logic                  illegal_q, illegal_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        base_d     = base_q;
        off_d      = off_q;
        rem_d      = rem_q;
        strb_d     = 4'b0000;
        mem_addr_d = '0;
        busy_d     = 1'b0;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if (opcode == OP_HALT) begin
                        state_d  = S_HALTED;
                        halted_d = 1'b1;
                    end else if (burst_op) begin
                        if (len_in != '0) begin
                            state_d    = S_EXEC;
                            op_d       = opcode;
                            base_d     = base_in;
                            off_d      = '0;
                            rem_d      = len_in - LEN_WIDTH'(1);
                            strb_d     = strobe_of(opcode);
                            mem_addr_d = base_in;
                            busy_d     = 1'b1;
                        end
                    end else if (opcode != OP_NOP) begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                // rem_q counts the strobe cycles still owed after the current one
                if (rem_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d      = rem_q - LEN_WIDTH'(1);
                    off_d      = off_q + ADDR_WIDTH'(1);
                    strb_d     = strobe_of(op_q);
                    mem_addr_d = base_q + off_d;
                    busy_d     = 1'b1;
                end
            end
            S_HALTED: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            base_q     <= '0;
            off_q      <= '0;
            rem_q      <= '0;
            strb_q     <= '0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            base_q     <= base_d;
            off_q      <= off_d;
            rem_q      <= rem_d;
            strb_q     <= strb_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign weight_we   = strb_q[0];
    assign input_re    = strb_q[1];
    assign sa_en       = strb_q[2];
    assign output_we   = strb_q[3];
    assign mem_addr    = mem_addr_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: transaction-level model (queue of expected
// strobe beats) checked every cycle, plus directed table and corner sequences.
module tb_instruction_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        instr_ready, weight_we, input_re, sa_en, output_we;
    logic [7:0]  mem_addr;
    logic        busy, halted, illegal;

    instruction_decoder dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid),
        .instruction(instruction), .instr_ready(instr_ready),
        .weight_we(weight_we), .input_re(input_re), .sa_en(sa_en),
        .output_we(output_we), .mem_addr(mem_addr), .busy(busy),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model: each accepted burst becomes L queued beats
    typedef struct packed {
        logic [3:0] strb;
        logic [7:0] addr;
    } beat_t;
    beat_t m_q[$];
    bit m_halted = 1'b0;
    bit m_illegal = 1'b0;

    task automatic model_accept(input logic [31:0] w);
        int op, base, len;
        beat_t b;
        op   = int'(w[31:28]);
        base = int'(w[27:20]);
        len  = int'(w[19:12]);
        if (op == 15) m_halted = 1'b1;
        else if (op >= 1 && op <= 4) begin
            for (int k = 0; k < len; k++) begin
                b.strb = 4'(1 << (op - 1));
                b.addr = 8'((base + k) % 256);
                m_q.push_back(b);
            end
        end else if (op != 0) m_illegal = 1'b1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_halted  = 1'b0;
            m_illegal = 1'b0;
        end else if (m_q.size() > 0) begin
            void'(m_q.pop_front());
        end else if (!m_halted && instr_valid) begin
            model_accept(instruction);
        end
    end

    function automatic bit m_ready();
        return (m_q.size() == 0) && !m_halted;
    endfunction

    int cnt[4];
    int n_strobe;
    logic [7:0] first_addr, last_addr;

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        n_strobe = 0;
        first_addr = '0;
        last_addr = '0;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string name);
        logic [15:0] got, exp;
        beat_t b;
        b = (m_q.size() > 0) ? m_q[0] : beat_t'(0);
        got = {output_we, sa_en, input_re, weight_we, mem_addr, busy, instr_ready, halted, illegal};
        exp = {b.strb, b.addr, (m_q.size() > 0), m_ready(), m_halted, m_illegal};
        check(name, got, exp);
    endtask

    task automatic step();
        logic [3:0] s;
        @(negedge clk);
        check_outputs("cycle");
        s = {output_we, sa_en, input_re, weight_we};
        for (int i = 0; i < 4; i++) if (s[i]) cnt[i]++;
        if (s != 4'b0) begin
            if (n_strobe == 0) first_addr = mem_addr;
            last_addr = mem_addr;
            n_strobe++;
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] base, input logic [7:0] len);
        return {op, base, len, 12'($urandom)};
    endfunction

    task automatic wait_ready();
        int guard = 0;
        while (!m_ready() && guard < 300) begin
            step();
            guard++;
        end
        if (!m_ready()) begin
            bad++;
            total++;
            $display("FAIL wait_ready: model not ready after %0d cycles", guard);
        end
    endtask

    task automatic issue(input logic [31:0] w);
        wait_ready();
        instruction = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instruction = $urandom;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] base;
        logic [7:0] len;
        int         idx;
        int         n;
        logic [7:0] first;
        logic [7:0] last;
        logic       ill;
    } vec_t;
    vec_t tbl[10];

    int exp_sum;

    initial begin
        tbl[0] = '{4'h1, 8'h10, 8'd3, 0, 3, 8'h10, 8'h12, 1'b0};
        tbl[1] = '{4'h3, 8'hFE, 8'd4, 2, 4, 8'hFE, 8'h01, 1'b0};
        tbl[2] = '{4'h2, 8'h00, 8'd1, 1, 1, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{4'h4, 8'h80, 8'd2, 3, 2, 8'h80, 8'h81, 1'b0};
        tbl[4] = '{4'h0, 8'h33, 8'd5, -1, 0, 8'h00, 8'h00, 1'b0};
        tbl[5] = '{4'h4, 8'h20, 8'd0, -1, 0, 8'h00, 8'h00, 1'b0};
        tbl[6] = '{4'h7, 8'h10, 8'd3, -1, 0, 8'h00, 8'h00, 1'b1};
        tbl[7] = '{4'h0, 8'h00, 8'd0, -1, 0, 8'h00, 8'h00, 1'b1};
        tbl[8] = '{4'h4, 8'h55, 8'd0, -1, 0, 8'h00, 8'h00, 1'b1};
        tbl[9] = '{4'h1, 8'hFF, 8'd2, 0, 2, 8'hFF, 8'h00, 1'b1};

        clear_counts();
        step();
        check("reset_state", {output_we, sa_en, input_re, weight_we, mem_addr, busy, halted, illegal}, 16'h0);
        reset_n = 1'b1;
        step();
        check("ready_after_reset", {15'h0, instr_ready}, 16'h1);

        for (int i = 0; i < 10; i++) begin
            wait_ready();
            clear_counts();
            issue(mk(tbl[i].op, tbl[i].base, tbl[i].len));
            for (int c = 0; c < int'(tbl[i].len) + 2; c++) step();
            check($sformatf("tbl%0d_count", i), 16'(n_strobe), 16'(tbl[i].n));
            if (tbl[i].idx >= 0) begin
                check($sformatf("tbl%0d_type", i), 16'(cnt[tbl[i].idx]), 16'(tbl[i].n));
                check($sformatf("tbl%0d_first", i), {8'h0, first_addr}, {8'h0, tbl[i].first});
                check($sformatf("tbl%0d_last", i), {8'h0, last_addr}, {8'h0, tbl[i].last});
            end
            check($sformatf("tbl%0d_illegal", i), {15'h0, illegal}, {15'h0, tbl[i].ill});
        end

        // random traffic with gaps and garbage while not ready
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        clear_counts();
        exp_sum = 0;
        for (int w = 0; w < 150; w++) begin
            logic [3:0] op;
            logic [7:0] len;
            int r, gap, guard;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                instr_valid = 1'b0;
                instruction = $urandom;
                step();
            end
            guard = 0;
            while (!m_ready() && guard < 300) begin
                instr_valid = 1'($urandom_range(0, 1));
                instruction = $urandom;
                step();
                guard++;
            end
            r = $urandom_range(0, 9);
            if (r == 0) op = 4'h0;
            else if (r == 9) op = 4'($urandom_range(5, 14));
            else op = 4'(1 + (r - 1) % 4);
            len = 8'($urandom_range(0, 6));
            if (op >= 4'd1 && op <= 4'd4) exp_sum += int'(len);
            issue(mk(op, 8'($urandom), len));
        end
        instr_valid = 1'b0;
        wait_ready();
        step();
        check("random_strobe_total", 16'(n_strobe), 16'(exp_sum));

        // reset in the middle of a LOAD_INPUT burst
        wait_ready();
        clear_counts();
        issue(mk(4'h2, 8'h40, 8'd10));
        for (int c = 0; c < 4; c++) step();
        check("abort_k4_addr", {8'h0, mem_addr}, 16'h0044);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {output_we, sa_en, input_re, weight_we, mem_addr, busy, halted, illegal}, 16'h0);
        check_outputs("abort_model");
        step();
        step();
        reset_n = 1'b1;
        check("abort_input_re_count", 16'(cnt[1]), 16'd5);
        clear_counts();
        issue(mk(4'h1, 8'h05, 8'd2));
        for (int c = 0; c < 3; c++) step();
        check("after_abort_weight", 16'(cnt[0]), 16'd2);
        check("after_abort_no_input", 16'(cnt[1]), 16'd0);
        check("after_abort_first", {8'h0, first_addr}, 16'h0005);

        // HALT, then a LOAD_INPUT held valid
        wait_ready();
        issue(mk(4'hF, 8'h00, 8'd0));
        clear_counts();
        instruction = mk(4'h2, 8'h11, 8'd4);
        instr_valid = 1'b1;
        for (int c = 0; c < 10; c++) step();
        check("halt_no_input_re", 16'(cnt[1]), 16'd0);
        check("halt_flags", {14'h0, halted, instr_ready}, 16'h2);
        instr_valid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check("halt_cleared", {14'h0, halted, instr_ready}, 16'h1);
        clear_counts();
        issue(mk(4'h2, 8'h7F, 8'd1));
        step();
        step();
        check("post_halt_input", 16'(cnt[1]), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
